main_memory_responder: RTL and testbench

Cycle-accurate main-memory responder for the memory-side request interface of the cache hierarchy. The lowest cache level issues a level-held request (valid, read/write, address, write data). This block accepts it, waits a programmable number of cycles, commits the write or fetches the read word, and answers with a one-cycle `mem_ready` pulse. It is the responding end of the same valid/read/write/address/data request protocol the CPU uses toward the caches, and it replaces the behavioural memory inside the top-level system.

---
 rtl/main_memory_responder.sv | 108 ++++++++++
 tb/tb_main_memory_responder.sv | 136 +++++++++++++
 2 files changed

// File: rtl/main_memory_responder.sv
// Word-addressed main memory behind a level-held request: accept, wait LATENCY cycles, commit or fetch, pulse mem_ready.
// Latency: LATENCY cycles from acceptance to mem_ready; the requester is held off by simply not seeing mem_ready.
module main_memory_responder #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req_valid,
    input  logic              mem_req_read,
    input  logic              mem_req_write,
    input  logic [ADDR_W-1:0] mem_req_address,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_ready
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state;
    logic [7:0]            cnt;
    logic [DEPTH_LOG2-1:0] addr_q;
    logic                  wr_q;
    logic [DATA_W-1:0]     dat_q;

    // Words are stored XORed with their own index, so an all-zero power-up image reads back as word i == i.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    logic                  accept;
    logic                  commit;
    logic                  c_wr;
    logic [DEPTH_LOG2-1:0] c_addr;
    logic [DATA_W-1:0]     c_dat;
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^mem_req_address[ADDR_W-1:DEPTH_LOG2];
    assign accept = (state == IDLE) && mem_req_valid && (mem_req_read || mem_req_write);

    function automatic logic [DATA_W-1:0] idx_word(input logic [DEPTH_LOG2-1:0] a);
        idx_word = '0;
        idx_word[DEPTH_LOG2-1:0] = a;
    endfunction

    // Operands for the edge that enters RESP; with LATENCY==1 that edge is the acceptance edge itself.
    always_comb begin
        commit = 1'b0;
        c_wr   = wr_q;
        c_addr = addr_q;
        c_dat  = dat_q;
        if (state == BUSY && cnt == 8'd1) begin
            commit = 1'b1;
        end
        if (LATENCY == 1 && accept) begin
            commit = 1'b1;
            c_wr   = mem_req_write;
            c_addr = mem_req_address[DEPTH_LOG2-1:0];
            c_dat  = mem_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && commit && c_wr) begin
            mem[c_addr] <= c_dat ^ idx_word(c_addr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            mem_ready  <= 1'b0;
            mem_data_o <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            dat_q      <= '0;
        end else begin
            mem_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q <= mem_req_address[DEPTH_LOG2-1:0];
                        wr_q   <= mem_req_write;
                        dat_q  <= mem_data_i;
                        cnt    <= CNT_INIT;
                        state  <= (LATENCY > 1) ? BUSY : RESP;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state <= RESP;
                    end
                end
                default: state <= IDLE;
            endcase
            if (commit) begin
                mem_ready <= 1'b1;
                if (!c_wr) begin
                    mem_data_o <= mem[c_addr] ^ idx_word(c_addr);
                end
            end
        end
    end
endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder: a LATENCY=4 instance and a LATENCY=1 instance sharing request fields.
module tb_main_memory_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v0 = 1'b0;
    logic        v1 = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [63:0] wdat = '0;
    logic [63:0] d0, d1;
    logic        rdy0, rdy1;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    main_memory_responder #(.DATA_W(64), .ADDR_W(32), .DEPTH_LOG2(12), .LATENCY(4)) dut0 (
        .clk(clk), .rst(rst), .mem_req_valid(v0), .mem_req_read(rd), .mem_req_write(wr),
        .mem_req_address(addr), .mem_data_i(wdat), .mem_data_o(d0), .mem_ready(rdy0)
    );

    main_memory_responder #(.DATA_W(64), .ADDR_W(32), .DEPTH_LOG2(12), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .mem_req_valid(v1), .mem_req_read(rd), .mem_req_write(wr),
        .mem_req_address(addr), .mem_data_i(wdat), .mem_data_o(d1), .mem_ready(rdy1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge; drives one request and waits for its response on the selected instance.
    task automatic txn(input bit sel, input logic r, input logic w, input logic [31:0] a,
                       input logic [63:0] wd, input logic [63:0] exp_d, input string tag);
        int  n;
        bit  got;
        int  lat;
        logic [63:0] e;
        lat = sel ? 1 : 4;
        exp_q.push_back(exp_d);
        rd = r; wr = w; addr = a; wdat = wd;
        if (sel) v1 = 1'b1; else v0 = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 30) begin
            @(negedge clk);
            n++;
            got = sel ? rdy1 : rdy0;
        end
        v0 = 1'b0; v1 = 1'b0; rd = 1'b0; wr = 1'b0;
        check({tag, "_ready"}, 64'(got), 64'd1);
        check({tag, "_lat"}, 64'(n), 64'(lat));
        e = exp_q.pop_front();
        check({tag, "_data"}, sel ? d1 : d0, e);
        @(negedge clk);
        check({tag, "_pulse"}, 64'(sel ? rdy1 : rdy0), 64'd0);
    endtask

    initial begin
        int n;
        int pulses;
        logic [63:0] e;

        repeat (3) @(negedge clk);
        check("rst_ready", 64'(rdy0), 64'd0);
        check("rst_data", d0, 64'd0);
        check("rst_ready1", 64'(rdy1), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        txn(0, 1, 0, 32'd164, 64'd0, 64'd164, "rd164");

        // Held valid: two identical reads, LATENCY+1 cycles apart.
        exp_q.push_back(64'd3236);
        exp_q.push_back(64'd3236);
        rd = 1'b1; wr = 1'b0; addr = 32'd3236; v0 = 1'b1;
        n = 0;
        while (!rdy0 && n < 30) begin @(negedge clk); n++; end
        check("held_lat1", 64'(n), 64'd4);
        e = exp_q.pop_front();
        check("held_data1", d0, e);
        n = 0;
        @(negedge clk);
        n++;
        check("held_gap", 64'(rdy0), 64'd0);
        while (!rdy0 && n < 30) begin @(negedge clk); n++; end
        check("held_period", 64'(n), 64'd5);
        e = exp_q.pop_front();
        check("held_data2", d0, e);
        v0 = 1'b0; rd = 1'b0;
        @(negedge clk);
        check("held_pulse", 64'(rdy0), 64'd0);

        txn(0, 0, 1, 32'd164, 64'hABCD, 64'd3236, "wr_abcd");
        txn(0, 1, 0, 32'd164, 64'd0, 64'hABCD, "rd_abcd");
        txn(0, 0, 1, 32'd164, 64'hABDA_ABDA, 64'hABCD, "wr_abda");
        txn(0, 1, 0, 32'h0001_00A4, 64'd0, 64'hABDA_ABDA, "rd_alias");

        txn(0, 1, 1, 32'd7, 64'h55, 64'hABDA_ABDA, "rw_both");
        txn(0, 1, 0, 32'd7, 64'd0, 64'h55, "rd7");

        // Valid with neither op must never be answered.
        v0 = 1'b1; rd = 1'b0; wr = 1'b0; addr = 32'd9;
        pulses = 0;
        repeat (10) begin @(negedge clk); if (rdy0) pulses++; end
        v0 = 1'b0;
        check("noop_pulses", 64'(pulses), 64'd0);

        // Reset lands while a write is still in BUSY.
        @(negedge clk);
        wr = 1'b1; rd = 1'b0; addr = 32'd10; wdat = 64'hFFFF; v0 = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1; v0 = 1'b0; wr = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", 64'(rdy0), 64'd0);
        check("mid_rst_data", d0, 64'd0);
        rst = 1'b0;
        pulses = 0;
        repeat (8) begin @(negedge clk); if (rdy0) pulses++; end
        check("mid_rst_pulses", 64'(pulses), 64'd0);
        txn(0, 1, 0, 32'd10, 64'd0, 64'd10, "rd10");

        txn(1, 1, 0, 32'd5, 64'd0, 64'd5, "l1_rd5");
        txn(1, 0, 1, 32'd5, 64'h1234, 64'd5, "l1_wr5");
        txn(1, 1, 0, 32'd5, 64'd0, 64'h1234, "l1_rd5b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
